// File: rtl/nios_system_sysid_pkg.sv
// Shared definitions for the system-ID checker.
//   state_t      : checker FSM states (also exported on the debug port)
//   ERR_*        : err_code encodings
//   ADDR_*       : word addresses inside the sysid slave
package nios_system_sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ID_REQ  = 3'd1,
    S_ID_WAIT = 3'd2,
    S_TS_REQ  = 3'd3,
    S_TS_WAIT = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ID      = 2'b01;
  localparam logic [1:0] ERR_TS      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID word (address 0) and the
// timestamp word (address 1) and compares them with build-time constants.
//
// Ports:
//   clock, reset_n        : rising-edge clock, async active-low reset
//   start                 : one-cycle pulse, launches a check when idle
//   avm_address/avm_read  : read request to the sysid slave
//   avm_waitrequest       : slave stall
//   avm_readdata/valid    : returned word and its qualifier
//   busy, done, pass      : status (done is sticky until the next launch)
//   err_code              : 00 ok, 01 ID mismatch, 10 TS mismatch, 11 timeout
//   id_value, ts_value    : last captured words
//   state_dbg             : current FSM state for observation
//
// Handshake: a read request (avm_read=1) is accepted on the first cycle in
// which avm_waitrequest=0; until then address and read are held unchanged.
// Returned data is qualified only by avm_readdatavalid, which may arrive in
// the acceptance cycle itself (zero latency) or any later cycle. Only one
// read is ever outstanding.
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h583C_F464,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_START     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output state_t      state_dbg
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic [15:0] to_cnt;
  logic        auto_pend;

  logic        in_req;
  logic        in_wait;
  logic        ts_phase;
  logic        got_data;
  logic [15:0] cnt_next;
  logic        hit_timeout;
  logic [1:0]  check_err;

  always_comb begin
    in_req      = (state == S_ID_REQ) || (state == S_TS_REQ);
    in_wait     = (state == S_ID_WAIT) || (state == S_TS_WAIT);
    ts_phase    = (state == S_TS_REQ) || (state == S_TS_WAIT);
    // Data counts in a WAIT state, or in the acceptance cycle itself.
    got_data    = avm_readdatavalid && (in_wait || (in_req && !avm_waitrequest));
    cnt_next    = to_cnt + 16'd1;
    hit_timeout = (cnt_next == TIMEOUT_LIMIT);
    if (id_value != EXPECTED_ID)      check_err = ERR_ID;
    else if (ts_value != EXPECTED_TS) check_err = ERR_TS;
    else                              check_err = ERR_OK;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      auto_pend   <= (AUTO_START != 0);
      to_cnt      <= 16'd0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_code    <= ERR_OK;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start || auto_pend) begin
            auto_pend   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_code    <= ERR_OK;
            avm_read    <= 1'b1;
            avm_address <= ADDR_ID;
            to_cnt      <= 16'd0;
            state       <= S_ID_REQ;
          end
        end

        S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT: begin
          if (got_data) begin
            if (ts_phase) begin
              ts_value <= avm_readdata;
              avm_read <= 1'b0;
              state    <= S_CHECK;
            end else begin
              // Back-to-back: the timestamp request follows immediately.
              id_value    <= avm_readdata;
              avm_read    <= 1'b1;
              avm_address <= ADDR_TS;
              to_cnt      <= 16'd0;
              state       <= S_TS_REQ;
            end
          end else if (hit_timeout) begin
            // Abort leaves the word being read at its previous value.
            avm_read <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
            err_code <= ERR_TIMEOUT;
            state    <= S_DONE;
          end else begin
            to_cnt <= cnt_next;
            if (in_req && !avm_waitrequest) begin
              avm_read <= 1'b0;
              state    <= ts_phase ? S_TS_WAIT : S_ID_WAIT;
            end
          end
        end

        S_CHECK: begin
          err_code <= check_err;
          pass     <= (check_err == ERR_OK);
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= S_DONE;
        end

        S_DONE:  state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Bench for nios_system_sysid_checker: a reactive Avalon slave with
// configurable stall/latency, a result model derived from the compare rules,
// and an expected address queue for the read strobes.
module tb_nios_system_sysid_checker;
  import nios_system_sysid_pkg::*;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h583C_F464;
  localparam int          TMO    = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err_code;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  state_t      state_dbg;

  int checks = 0;
  int errors = 0;

  // slave configuration (lat < 0 means data never returns)
  logic [31:0] slv_id, slv_ts;
  int          slv_stall = 0;
  int          slv_lat   = 0;

  logic [0:0]  acc_q[$];
  logic [0:0]  exp_q[$];

  // reference model of captured words
  logic [31:0] m_id = 32'd0;
  logic [31:0] m_ts = 32'd0;

  nios_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(TMO), .AUTO_START(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code),
    .id_value(id_value), .ts_value(ts_value), .state_dbg(state_dbg)
  );

  // clock
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_err(input logic [31:0] idw, input logic [31:0] tsw);
    if (idw != EXP_ID) return 2'd1;
    if (tsw != EXP_TS) return 2'd2;
    return 2'd0;
  endfunction

  // Reactive slave, updated at negedges.
  initial begin
    int          stall_left;
    int          pend_cnt;
    bit          pend_active;
    bit          in_req;
    bit          prev_wr;
    logic        held_addr;
    logic [31:0] pend_data;
    logic [31:0] word;
    stall_left = 0; pend_cnt = 0; pend_active = 0; in_req = 0; prev_wr = 0;
    held_addr = 0; pend_data = 0;
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        stall_left = 0; pend_active = 0; in_req = 0; prev_wr = 0;
        avm_waitrequest = 0; avm_readdatavalid = 0;
      end else begin
        avm_readdatavalid = 0;
        avm_readdata = $urandom();
        if (prev_wr) begin
          chk("hold_read", 32'(avm_read), 32'd1);
          chk("hold_addr", 32'(avm_address), 32'(held_addr));
        end
        if (pend_active) begin
          if (pend_cnt == 0) begin
            avm_readdatavalid = 1; avm_readdata = pend_data; pend_active = 0;
          end else pend_cnt--;
        end
        avm_waitrequest = 0;
        if (avm_read === 1'b1) begin
          if (!in_req) begin in_req = 1; stall_left = slv_stall; end
          if (stall_left > 0) begin
            avm_waitrequest = 1; stall_left--; held_addr = avm_address;
          end else begin
            in_req = 0;
            acc_q.push_back(avm_address);
            chk("one_outstanding", 32'(pend_active), 32'd0);
            word = avm_address ? slv_ts : slv_id;
            if (slv_lat == 0) begin
              avm_readdatavalid = 1; avm_readdata = word;
            end else if (slv_lat > 0) begin
              pend_active = 1; pend_cnt = slv_lat - 1; pend_data = word;
            end
          end
        end else in_req = 0;
        prev_wr = avm_waitrequest;
      end
    end
  end

  task automatic configure(input logic [31:0] idw, input logic [31:0] tsw,
                           input int stall, input int lat);
    slv_id = idw; slv_ts = tsw; slv_stall = stall; slv_lat = lat;
    acc_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk("done_seen", 32'(cyc < 200), 32'd1);
  endtask

  task automatic compare_result(input string tag);
    logic [1:0] e_err;
    exp_q.delete();
    if (slv_lat < 0) begin
      e_err = 2'd3;
      exp_q.push_back(1'b0);
    end else begin
      m_id = slv_id; m_ts = slv_ts;
      e_err = ref_err(slv_id, slv_ts);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_read"}, 32'(avm_read), 32'd0);
    chk({tag, "_err"}, 32'(err_code), 32'(e_err));
    chk({tag, "_pass"}, 32'(pass), 32'(e_err == 2'd0));
    chk({tag, "_id"}, id_value, m_id);
    chk({tag, "_ts"}, ts_value, m_ts);
    chk({tag, "_nreads"}, 32'(acc_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && acc_q.size() > 0)
      chk({tag, "_addr"}, 32'(acc_q.pop_front()), 32'(exp_q.pop_front()));
  endtask

  task automatic check_zeroed(input string tag);
    chk({tag, "_read"}, 32'(avm_read), 32'd0);
    chk({tag, "_addr"}, 32'(avm_address), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"}, 32'(err_code), 32'd0);
    chk({tag, "_id"}, id_value, 32'd0);
    chk({tag, "_ts"}, ts_value, 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
  endtask

  initial begin
    int cyc;
    logic [31:0] idw, tsw;
    reset_n = 1'b0;
    start   = 1'b0;
    configure(EXP_ID, EXP_TS, 0, 0);
    repeat (3) @(negedge clock);
    check_zeroed("reset");

    // 1: auto-start after reset, zero-latency slave
    reset_n = 1'b1;
    wait_done(cyc);
    chk("t1_latency_le8", 32'(cyc <= 8), 32'd1);
    compare_result("t1");

    // 2: timestamp off by one
    configure(EXP_ID, 32'h583C_F465, 0, 0);
    pulse_start();
    wait_done(cyc);
    compare_result("t2");

    // 3: 5-cycle stall, 3-cycle data latency
    configure(EXP_ID, EXP_TS, 5, 3);
    pulse_start();
    wait_done(cyc);
    compare_result("t3");

    // randomized checks
    for (int i = 0; i < 12; i++) begin
      idw = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
      tsw = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
      configure(idw, tsw, $urandom_range(0, 4), $urandom_range(0, 4));
      pulse_start();
      wait_done(cyc);
      compare_result("rnd");
    end

    // ID mismatch, leaves a distinctive id_value for the timeout step
    configure(32'hDEAD_BEEF, EXP_TS, 1, 1);
    pulse_start();
    wait_done(cyc);
    compare_result("idmis");

    // 4: no data ever returns
    configure(32'h1234_5678, EXP_TS, 0, -1);
    pulse_start();
    chk("t4_read_up", 32'(avm_read), 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    chk("t4_cycles", 32'(cyc), 32'(TMO));
    compare_result("t4");

    // 5: start while busy ignored; start in DONE cycle ignored; next accepted
    configure(EXP_ID, EXP_TS, 3, 2);
    pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_done(cyc);
    compare_result("t5a");
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("t5_done_cycle_start_done", 32'(done), 32'd1);
    chk("t5_done_cycle_start_busy", 32'(busy), 32'd0);
    configure(EXP_ID, 32'h0BAD_0000, 0, 1);
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("t5_relaunch_done", 32'(done), 32'd0);
    chk("t5_relaunch_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    compare_result("t5b");

    // 6: reset during TS_WAIT, then auto-start rerun
    configure(EXP_ID, EXP_TS, 0, 10);
    pulse_start();
    cyc = 0;
    while (acc_q.size() < 2 && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    chk("t6_ts_accepted", 32'(acc_q.size()), 32'd2);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_zeroed("t6_async");
    m_id = 32'd0; m_ts = 32'd0;
    configure(EXP_ID, EXP_TS, 2, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_done(cyc);
    compare_result("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
